clock_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It owns the run/set mode, sequences hour-then-minute editing from two front-panel keys, and holds the BCD set values while they are edited. It issues a one-cycle load strobe to the timekeeper and generates the digit-scan enable tick for the 7-segment scan driver. It sits between the debounced key inputs, the timekeeper (BCD hour/minute counters) and the display scan driver.

---
 rtl/clock_pkg.sv | 12 +
 rtl/clock_set_ctrl_if.sv | 15 +
 rtl/key_edge_sync.sv | 14 +
 rtl/clock_set_ctrl.sv | 73 +++++++
 tb/tb_clock_set_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared states, BCD limits and BCD helpers for the digital clock
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_H, SET_M, LOAD} state_t;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'h00 : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max) ? 8'h00 : v;
  endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: key, timekeeper and display signals of the set controller
interface clock_set_ctrl_if;
  logic key_mode;
  logic key_inc;
  logic [7:0] cur_h;
  logic [7:0] cur_m;
  logic mode;
  logic field;
  logic [7:0] set_h;
  logic [7:0] set_m;
  logic load;
  logic scan_en;
  modport master (output key_mode, key_inc, cur_h, cur_m, input mode, field, set_h, set_m, load, scan_en);
  modport slave (input key_mode, key_inc, cur_h, cur_m, output mode, field, set_h, set_m, load, scan_en);
endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer followed by a rising-edge one-cycle pulse
module key_edge_sync (
  input logic clk,
  input logic rstn,
  input logic key,
  output logic evt
);
  logic [2:0] q;
  // shift the key through two sync flops and one history flop
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else q <= {q[1:0], key};
  assign evt = q[1] & ~q[2];
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode sequencing, BCD set values, load strobe and scan tick
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned TIMEOUT_TICKS = 10000
) (
  input logic clk,
  input logic rstn,
  clock_set_ctrl_if.slave bus
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  state_t state, nxt;
  logic mode_evt, inc_evt, to_hit, editing, scan_en;
  logic [SW-1:0] scan_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] set_h, set_m;
  key_edge_sync u_mode (.clk(clk), .rstn(rstn), .key(bus.key_mode), .evt(mode_evt));
  key_edge_sync u_inc (.clk(clk), .rstn(rstn), .key(bus.key_inc), .evt(inc_evt));
  assign editing = (state == SET_H) || (state == SET_M);
  assign to_hit = scan_en && (to_cnt == TW'(TIMEOUT_TICKS - 1));
  // state register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= RUN;
    else state <= nxt;
  // next state: mode beats inc, any key beats timeout
  always_comb begin
    nxt = state;
    case (state)
      RUN: nxt = mode_evt ? SET_H : RUN;
      SET_H: nxt = mode_evt ? SET_M : (!inc_evt && to_hit) ? RUN : SET_H;
      SET_M: nxt = mode_evt ? LOAD : (!inc_evt && to_hit) ? RUN : SET_M;
      default: nxt = RUN;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    bus.mode = editing;
    bus.field = state == SET_M;
    bus.load = state == LOAD;
  end
  // set values: capture (sanitised) on entry, BCD increment while editing
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      set_h <= 8'h00;
      set_m <= 8'h00;
    end else if (state == RUN && mode_evt) begin
      set_h <= bcd_sanitize(bus.cur_h, HOUR_MAX);
      set_m <= bcd_sanitize(bus.cur_m, MIN_MAX);
    end else if (state == SET_H && !mode_evt && inc_evt) begin
      set_h <= bcd_inc(set_h, HOUR_MAX);
    end else if (state == SET_M && !mode_evt && inc_evt) begin
      set_m <= bcd_inc(set_m, MIN_MAX);
    end
  // inactivity counter: counts scan ticks while editing, cleared by any key
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) to_cnt <= '0;
    else if (!editing || mode_evt || inc_evt) to_cnt <= '0;
    else if (scan_en) to_cnt <= to_cnt + 1'b1;
  // free-running scan divider with a registered tick
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      scan_cnt <= '0;
      scan_en <= 1'b0;
    end else begin
      scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + 1'b1;
      scan_en <= scan_cnt == SW'(SCAN_DIV - 1);
    end
  assign bus.set_h = set_h;
  assign bus.set_m = set_m;
  assign bus.scan_en = scan_en;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
  logic clk = 0;
  logic rstn = 0;
  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  logic [7:0] ld_h = 8'hxx, ld_m = 8'hxx;
  clock_set_ctrl_if bus();
  clock_set_ctrl #(.SCAN_DIV(4), .TIMEOUT_TICKS(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  // record every cycle load is high and the set values presented with it
  always @(posedge clk)
    if (bus.load === 1'b1) begin
      load_cnt++;
      ld_h = bus.set_h;
      ld_m = bus.set_m;
    end
  task automatic press(input bit m, input bit i);
    @(negedge clk);
    bus.key_mode = m;
    bus.key_inc = i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.key_mode = 0;
    bus.key_inc = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic test_reset;
    bus.key_mode = 0;
    bus.key_inc = 0;
    bus.cur_h = 8'h00;
    bus.cur_m = 8'h00;
    rstn = 0;
    repeat (3) @(negedge clk);
    chk8("rst_outs", {2'b0, bus.mode, bus.field, bus.load, bus.scan_en, 2'b0}, 8'h00);
    chk8("rst_set_h", bus.set_h, 8'h00);
    chk8("rst_set_m", bus.set_m, 8'h00);
    rstn = 1;
  endtask
  task automatic test_scan;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if (bus.scan_en !== ((k % 4) == 0)) begin
        bad++;
        $display("FAIL scan_en cycle=%0d got=%b exp=%b", k, bus.scan_en, (k % 4) == 0);
      end
    end
    chk8("idle_outs", {bus.mode, bus.field, bus.load, 5'b0}, 8'h00);
    chk8("idle_set_h", bus.set_h, 8'h00);
  endtask
  task automatic test_set_hour;
    bus.cur_h = 8'h21;
    bus.cur_m = 8'h58;
    press(1, 0);
    chk8("enter_mode_field", {bus.mode, bus.field, 6'b0}, 8'h80);
    chk8("cap_h", bus.set_h, 8'h21);
    chk8("cap_m", bus.set_m, 8'h58);
    press(0, 1);
    chk8("inc_h1", bus.set_h, 8'h22);
    press(0, 1);
    chk8("inc_h2", bus.set_h, 8'h23);
    press(0, 1);
    chk8("inc_h_wrap", bus.set_h, 8'h00);
  endtask
  task automatic test_set_min;
    press(1, 0);
    chk8("setm_mode_field", {bus.mode, bus.field, 6'b0}, 8'hC0);
    press(0, 1);
    chk8("inc_m1", bus.set_m, 8'h59);
    press(0, 1);
    chk8("inc_m_wrap", bus.set_m, 8'h00);
    chk8("no_load_yet", 8'(load_cnt), 8'd0);
    press(1, 0);
    chk8("load_once", 8'(load_cnt), 8'd1);
    chk8("load_h", ld_h, 8'h00);
    chk8("load_m", ld_m, 8'h00);
    chk8("after_load_mode", {bus.mode, bus.field, bus.load, 5'b0}, 8'h00);
    press(0, 1);
    chk8("run_inc_ignored", bus.set_h, 8'h00);
    chk8("run_inc_mode", {7'b0, bus.mode}, 8'h00);
  endtask
  task automatic test_sanitize;
    bus.cur_h = 8'h2A;
    bus.cur_m = 8'h60;
    press(1, 0);
    chk8("san_h", bus.set_h, 8'h00);
    chk8("san_m", bus.set_m, 8'h00);
    chk8("san_mode", {7'b0, bus.mode}, 8'h01);
  endtask
  task automatic test_both_keys;
    press(1, 1);
    chk8("both_field", {bus.mode, bus.field, 6'b0}, 8'hC0);
    chk8("both_set_h", bus.set_h, 8'h00);
    chk8("both_set_m", bus.set_m, 8'h00);
  endtask
  task automatic test_hold;
    @(negedge clk);
    bus.key_inc = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk8("hold_first", bus.set_m, 8'h01);
    repeat (96) @(negedge clk);
    bus.key_inc = 0;
    repeat (3) @(negedge clk);
    chk8("hold_once", bus.set_m, 8'h01);
    chk8("hold_timeout_mode", {7'b0, bus.mode}, 8'h00);
    chk8("hold_no_load", 8'(load_cnt), 8'd1);
  endtask
  task automatic test_timeout;
    int n = 0;
    bit done = 0;
    bus.cur_h = 8'h12;
    bus.cur_m = 8'h34;
    @(negedge clk);
    bus.key_mode = 1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      bus.key_mode = 0;
      if (bus.scan_en === 1'b1) n++;
      if (n == 8) begin
        done = 1;
        chk8("to_before", {7'b0, bus.mode}, 8'h01);
        @(posedge clk);
        #1;
        chk8("to_after", {7'b0, bus.mode}, 8'h00);
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL to_ticks got=%0d exp=8", n);
    end
    chk8("to_set_h", bus.set_h, 8'h12);
    chk8("to_set_m", bus.set_m, 8'h34);
    repeat (3) @(negedge clk);
    chk8("to_no_load", 8'(load_cnt), 8'd1);
  endtask
  task automatic test_reset_mid;
    press(1, 0);
    press(1, 0);
    chk8("mid_field", {bus.mode, bus.field, 6'b0}, 8'hC0);
    @(negedge clk);
    rstn = 0;
    #1;
    chk8("mid_outs", {bus.mode, bus.field, bus.load, bus.scan_en, 4'b0}, 8'h00);
    chk8("mid_set_h", bus.set_h, 8'h00);
    chk8("mid_set_m", bus.set_m, 8'h00);
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (3) @(negedge clk);
    chk8("mid_after_mode", {7'b0, bus.mode}, 8'h00);
    chk8("mid_no_load", 8'(load_cnt), 8'd1);
  endtask
  initial begin
    test_reset;
    test_scan;
    test_set_hour;
    test_set_min;
    test_sanitize;
    test_both_keys;
    test_hold;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
